spi_ram_ctrl: RTL and testbench

SPI slave front-end that sequences the single-port SPI RAM (spi_ram) from a serial master. It deserialises MOSI frames of DATA_W+2 bits (2-bit opcode + DATA_W payload, MSB first) into rx_data/rx_valid for the RAM. It also tracks the read-address / read-data command order. When the RAM returns read data (tx_valid/tx_data), it serialises that data back out on MISO. The serial clock is the system clock: one bit per clk edge while ss_n is low.

---
 rtl/spi_ram_ctrl.sv | 130 +++++++++++++
 tb/tb_spi_ram_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// SPI slave front-end for the single-port SPI RAM: deserialises opcode+payload
// frames from MOSI and serialises RAM read data back out on MISO.
module spi_ram_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_addr_done_q, rd_addr_done_d;
    logic [DATA_W-1:0]    tx_sh_q, tx_sh_d;
    logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 tx_active_q, tx_active_d;
    logic                 tx_done_q, tx_done_d;
    logic                 miso_q, miso_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            frame_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_sh_q        <= '0;
            tx_cnt_q       <= '0;
            tx_active_q    <= 1'b0;
            tx_done_q      <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_q        <= frame_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_sh_q        <= tx_sh_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_active_q    <= tx_active_d;
            tx_done_q      <= tx_done_d;
            miso_q         <= miso_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        frame_d        = frame_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_sh_d        = tx_sh_q;
        tx_cnt_d       = tx_cnt_q;
        tx_active_d    = tx_active_q;
        tx_done_d      = tx_done_q;
        miso_d         = 1'b0;

        if (ss_n) begin
            state_d     = IDLE;
            cnt_d       = '0;
            tx_cnt_d    = '0;
            tx_active_d = 1'b0;
            tx_done_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    frame_d = {{(FRAME_W-1){1'b0}}, mosi};
                    cnt_d   = CNT_W'(1);
                    if (!mosi)               state_d = WRITE;
                    else if (rd_addr_done_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                default: begin
                    if (cnt_q < CNT_W'(FRAME_W)) begin
                        frame_d = {frame_q[FRAME_W-2:0], mosi};
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            rx_data_d  = frame_d;
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD)  rd_addr_done_d = 1'b1;
                            if (state_q == READ_DATA) rd_addr_done_d = 1'b0;
                        end
                    end
                    // Read return: one load per READ_DATA window, then DATA_W bits MSB first.
                    if (state_q == READ_DATA) begin
                        if (tx_active_q) begin
                            if (tx_cnt_q == TXC_W'(DATA_W)) begin
                                tx_active_d = 1'b0;
                                tx_done_d   = 1'b1;
                            end else begin
                                miso_d   = tx_sh_q[DATA_W-1];
                                tx_sh_d  = tx_sh_q << 1;
                                tx_cnt_d = tx_cnt_q + TXC_W'(1);
                            end
                        end else if (!tx_done_q && cnt_q == CNT_W'(FRAME_W) && tx_valid) begin
                            miso_d      = tx_data[DATA_W-1];
                            tx_sh_d     = tx_data << 1;
                            tx_cnt_d    = TXC_W'(1);
                            tx_active_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: frames driven bit-serially, a small RAM
// model supplies read data, a queue scoreboards rx_data.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst, ss_n, mosi, tx_valid;
    logic       miso, rx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;

    int         total = 0;
    int         bad   = 0;
    logic [9:0] rx_q[$];
    logic [7:0] mem[256];
    logic [7:0] waddr, raddr;
    bit         tx_window = 1'b0;

    spi_ram_ctrl #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                logic [31:0] exp;
                exp = (rx_q.size() > 0) ? {22'd0, rx_q.pop_front()} : 32'hFFFF_FFFF;
                check("rx_data", {22'd0, rx_data}, exp);
            end
            if (!tx_window) check("miso_idle", {31'd0, miso}, 32'd0);
        end
    end

    // Sends nbits of frame f; returns at the negedge after E11 with ss_n still low.
    task automatic frame(input logic [9:0] f, input int nbits);
        @(negedge clk);
        ss_n = 1'b0;
        mosi = f[9];
        for (int k = 1; k <= nbits; k++) begin
            @(negedge clk);
            mosi = f[10-k];
        end
        if (nbits == 10) begin
            rx_q.push_back(f);
            case (f[9:8])
                2'b00: waddr = f[7:0];
                2'b01: mem[waddr] = f[7:0];
                2'b10: raddr = f[7:0];
                default: ;
            endcase
            @(negedge clk);
            check("rxv_hi", {31'd0, rx_valid}, 32'd1);
            @(negedge clk);
            check("rxv_lo", {31'd0, rx_valid}, 32'd0);
        end else begin
            @(negedge clk);
            ss_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("rxv_abort", {31'd0, rx_valid}, 32'd0);
            end
        end
    endtask

    task automatic serve(input logic [7:0] d, input int hold, input bit exp_en);
        int jmax;
        jmax = ((hold > 10) ? hold : 10) + 2;
        tx_window = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = d;
        for (int j = 0; j < jmax; j++) begin
            logic exp_bit;
            @(negedge clk);
            exp_bit = (exp_en && j < 8) ? d[7-j] : 1'b0;
            check("miso_bit", {31'd0, miso}, {31'd0, exp_bit});
            if (j == hold - 1) tx_valid = 1'b0;
        end
        tx_window = 1'b0;
    endtask

    task automatic release_ss();
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        foreach (mem[i]) mem[i] = '0;
        waddr = '0; raddr = '0;
        #1;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_rxv", {31'd0, rx_valid}, 32'd0);
        check("rst_rxd", {22'd0, rx_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // writes, back-to-back with one idle cycle between windows
        frame(10'h03C, 10); release_ss();
        frame(10'h1A5, 10); release_ss();
        frame(10'h010, 10); release_ss();
        frame(10'h15A, 10); release_ss();

        // read address then read data; then rd_addr_done must be clear again
        frame(10'h23C, 10); serve(8'hFF, 3, 1'b0); release_ss();
        frame(10'h300, 10); serve(mem[raddr], 3, 1'b1); release_ss();
        frame(10'h210, 10); serve(8'hFF, 3, 1'b0); release_ss();
        frame(10'h300, 10); serve(mem[raddr], 1, 1'b1); release_ss();

        // abort mid read-address frame; next command still a read-address
        frame(10'h23C, 5);
        frame(10'h23C, 10); serve(8'hFF, 3, 1'b0); release_ss();
        frame(10'h300, 10); serve(mem[raddr], 2, 1'b1); release_ss();

        // sticky tx_valid
        frame(10'h23C, 10); release_ss();
        frame(10'h300, 10); serve(8'hFF, 20, 1'b1); release_ss();

        // async reset mid-transmit
        frame(10'h23C, 10); release_ss();
        frame(10'h300, 10);
        tx_window = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_miso", {31'd0, miso}, 32'd0);
        check("arst_rxv", {31'd0, rx_valid}, 32'd0);
        check("arst_rxd", {22'd0, rx_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0; ss_n = 1'b1;
        @(negedge clk);
        tx_window = 1'b0;
        frame(10'h23C, 10); serve(8'hFF, 3, 1'b0); release_ss();
        frame(10'h300, 10); serve(mem[raddr], 2, 1'b1); release_ss();

        repeat (3) @(negedge clk);
        check("rx_pending", rx_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
